// File: rtl/neuron_accumulator_if.sv
// neuron_accumulator_if: product beats in, group sums out, flush/busy side signals.
// The bias lane exists only when NEURON_ACCUM_BIAS_EN is defined.
interface neuron_accumulator_if #(
   parameter int NC = 4,
   parameter int WF = 4,
   parameter int WA = 6
);
   logic prod_valid, prod_ready, flush, acc_valid, acc_ready, busy;
   logic [NC*WF-1:0] prod_data;
   logic [NC*WA-1:0] acc_data;
`ifdef NEURON_ACCUM_BIAS_EN
   logic [NC*WF-1:0] bias;
`endif
   modport master (
      output prod_valid, prod_data, flush, acc_ready,
`ifdef NEURON_ACCUM_BIAS_EN
      output bias,
`endif
      input prod_ready, acc_valid, acc_data, busy
   );
   modport slave (
      input prod_valid, prod_data, flush, acc_ready,
`ifdef NEURON_ACCUM_BIAS_EN
      input bias,
`endif
      output prod_ready, acc_valid, acc_data, busy
   );
endinterface

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums NP signed product beats per channel and hands each group sum downstream.
// Optional per-channel bias with output saturation when NEURON_ACCUM_BIAS_EN is defined.
module neuron_accumulator #(
   parameter int NP = 4,
   parameter int NC = 4,
   parameter int WF = 4
) (
   input logic iCLK,
   input logic iRST,
   neuron_accumulator_if.slave bus
);
   localparam int WA = $clog2(NP) + WF;
   localparam int CW = NP > 1 ? $clog2(NP) : 1;
   typedef enum logic {ACCUM, HOLD} state_t;
   state_t state, state_nx;
   logic [CW-1:0] k;
   logic beat, last;
   logic [NC-1:0][WA-1:0] dout;
   always_ff @(posedge iCLK) state <= iRST ? ACCUM : state_nx;
   // a last beat always lands in HOLD, even when it arrives on the draining handshake
   always_comb state_nx = last ? HOLD : (state == HOLD && !bus.acc_ready) ? HOLD : ACCUM;
   always_comb begin
      bus.prod_ready = !bus.flush && (state == ACCUM || bus.acc_ready);
      bus.acc_valid = state == HOLD;
      bus.busy = state == ACCUM && k != '0;
   end
   assign beat = bus.prod_valid && bus.prod_ready;
   assign last = beat && k == CW'(NP - 1);
   assign bus.acc_data = dout;
   always_ff @(posedge iCLK)
      if (iRST || bus.flush) k <= '0;
      else if (beat) k <= last ? '0 : k + 1'b1;
   for (genvar c = 0; c < NC; c++) begin : g_ch
      logic signed [WA:0] acc, base, sum;
      logic [WA-1:0] res, out;
      logic [WF-1:0] p;
      assign p = bus.prod_data[c*WF +: WF];
`ifdef NEURON_ACCUM_BIAS_EN
      localparam logic signed [WA:0] SMAX = (WA + 1)'(2 ** (WA - 1) - 1);
      localparam logic signed [WA:0] SMIN = ~SMAX;
      logic [WF-1:0] b;
      assign b = bus.bias[c*WF +: WF];
      assign base = {{(WA + 1 - WF){b[WF-1]}}, b};
      assign res = sum > SMAX ? SMAX[WA-1:0] : sum < SMIN ? SMIN[WA-1:0] : sum[WA-1:0];
`else
      assign base = '0;
      assign res = sum[WA-1:0];
`endif
      // the first beat of a group restarts from the bias (or zero), discarding the old total
      assign sum = (k == '0 ? base : acc) + {{(WA + 1 - WF){p[WF-1]}}, p};
      assign dout[c] = out;
      always_ff @(posedge iCLK)
         if (iRST) begin
            acc <= '0;
            out <= '0;
         end else if (bus.flush) acc <= '0;
         else if (beat) begin
            acc <= sum;
            if (last) out <= res;
         end
   end
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed vector table plus backpressure, reset, flush and streaming sequences.
module tb_neuron_accumulator;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   neuron_accumulator_if #(.NC(4), .WF(4), .WA(6)) bus();
   neuron_accumulator #(.NP(4), .NC(4), .WF(4)) dut (.iCLK(clk), .iRST(rst), .bus(bus));
   typedef struct {
      logic [3:0][15:0] beats;
      logic [23:0] exp;
   } vec_t;
   vec_t vecs [4];
   int gv [3] = '{1, 2, -1};
   function automatic logic [15:0] p4(int a, int b, int c, int d);
      return {4'(d), 4'(c), 4'(b), 4'(a)};
   endfunction
   function automatic logic [15:0] all4(int a);
      return p4(a, a, a, a);
   endfunction
   function automatic logic [23:0] e6(int a, int b, int c, int d);
      return {6'(d), 6'(c), 6'(b), 6'(a)};
   endfunction
   function automatic logic [23:0] all6(int a);
      return e6(a, a, a, a);
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string n, logic [23:0] act, logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", n, act, exp);
      end
   endtask
   task automatic beat(logic [15:0] d);
      bus.prod_valid = 1'b1;
      bus.prod_data = d;
      step();
   endtask
   task automatic idle();
      bus.prod_valid = 1'b0;
      step();
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end
   initial begin
      vecs[0].beats = {p4(-1, 0, 0, 0), p4(3, 0, 0, 0), p4(2, 0, 0, 0), p4(1, 0, 0, 0)};
      vecs[0].exp = e6(5, 0, 0, 0);
      vecs[1].beats = {4{all4(-8)}};
      vecs[1].exp = all6(-32);
      vecs[2].beats = {4{all4(7)}};
      vecs[2].exp = all6(28);
      vecs[3].beats = {p4(-8, -1, 0, -7), p4(7, -1, 0, 6), p4(-8, -1, 0, 2), p4(7, -1, 5, -3)};
      vecs[3].exp = e6(-2, -4, 5, -2);
      bus.prod_valid = 1'b0;
      bus.prod_data = '0;
      bus.flush = 1'b0;
      bus.acc_ready = 1'b1;
`ifdef NEURON_ACCUM_BIAS_EN
      bus.bias = '0;
`endif
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_valid", bus.acc_valid, 0);
      chk("rst_data", bus.acc_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", bus.prod_ready, 1);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) beat(vecs[i].beats[j]);
         chk($sformatf("vec%0d_valid", i), bus.acc_valid, 1);
         chk($sformatf("vec%0d_data", i), bus.acc_data, vecs[i].exp);
         idle();
         chk($sformatf("vec%0d_drop", i), bus.acc_valid, 0);
      end
      // backpressure: sum held, producer stalled, then zero-bubble restart
      bus.acc_ready = 1'b0;
      for (int j = 0; j < 4; j++) beat(all4(7));
      bus.prod_data = all4(1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp%0d_ready", i), bus.prod_ready, 0);
         chk($sformatf("bp%0d_valid", i), bus.acc_valid, 1);
         chk($sformatf("bp%0d_data", i), bus.acc_data, all6(28));
         step();
      end
      bus.acc_ready = 1'b1;
      #1;
      chk("bp_release_ready", bus.prod_ready, 1);
      step();
      chk("bp_next_valid", bus.acc_valid, 0);
      chk("bp_next_busy", bus.busy, 1);
      for (int j = 0; j < 3; j++) beat(all4(1));
      chk("bp_next_sum_valid", bus.acc_valid, 1);
      chk("bp_next_sum", bus.acc_data, all6(4));
      idle();
      // reset mid-group
      beat(all4(3));
      beat(all4(3));
      chk("rstseq_busy", bus.busy, 1);
      bus.prod_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstseq_busy_clr", bus.busy, 0);
      for (int j = 0; j < 4; j++) beat(all4(1));
      chk("rstseq_valid", bus.acc_valid, 1);
      chk("rstseq_sum", bus.acc_data, all6(4));
      idle();
      // flush mid-group, with a beat offered during the flush
      beat(all4(3));
      beat(all4(3));
      bus.flush = 1'b1;
      bus.prod_data = all4(3);
      #1;
      chk("flush_ready", bus.prod_ready, 0);
      step();
      bus.flush = 1'b0;
      chk("flush_busy_clr", bus.busy, 0);
      for (int j = 0; j < 4; j++) beat(all4(1));
      chk("flush_valid", bus.acc_valid, 1);
      chk("flush_sum", bus.acc_data, all6(4));
      idle();
      // streaming: three groups back to back
      for (int i = 0; i < 12; i++) begin
         beat(all4(gv[i/4]));
         chk($sformatf("stream%0d_valid", i), bus.acc_valid, (i % 4 == 3) ? 24'd1 : 24'd0);
         if (i % 4 == 3) chk($sformatf("stream%0d_data", i), bus.acc_data, all6(4 * gv[i/4]));
      end
      idle();
      chk("stream_end_valid", bus.acc_valid, 0);
`ifdef NEURON_ACCUM_BIAS_EN
      bus.bias = all4(7);
      beat(all4(7));
      bus.bias = '0;
      for (int j = 0; j < 3; j++) beat(all4(7));
      chk("bias_pos_sat", bus.acc_data, all6(31));
      idle();
      bus.bias = all4(-8);
      for (int j = 0; j < 4; j++) beat(all4(-8));
      chk("bias_neg_sat", bus.acc_data, all6(-32));
      bus.bias = '0;
      idle();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
